// File: rtl/mul_sequencer.sv
// Iterative shift-add MUL sequencer for the RV32 EX stage: stalls the pipeline while busy,
// then strobes done_o/RegWrite_o for one cycle. Define MUL_EARLY_TERM_EN for early exit on exhausted multiplier.
module mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    input  logic [4:0]       rd_addr_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             RegWrite_o,
    output logic [4:0]       rd_addr_o,
    output logic [WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       rd_q;
    logic             accept, last_iter;

    // A new MUL is taken from IDLE or straight out of DONE (back-to-back issue).
    assign accept = (state != BUSY) && start_i && !flush_i;

`ifdef MUL_EARLY_TERM_EN
    assign last_iter = (cnt == CNT_W'(WIDTH-1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt == CNT_W'(WIDTH-1));
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY: begin
                if (flush_i)        state_nxt = IDLE;
                else if (last_iter) state_nxt = DONE;
            end
            DONE:    state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state == BUSY);
        done_o  = (state == DONE);
        stall_o = accept || (state == BUSY);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= rs1_data_i;
            mplier <= rs2_data_i;
            cnt    <= '0;
            rd_q   <= rd_addr_i;
        end else if (state == BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign RegWrite_o = done_o;
    assign rd_addr_o  = rd_q;
    assign result_o   = acc;

endmodule
